// File: rtl/fx1_issue_ctrl.sv
// Issue/writeback controller for the even-pipe FX1 fixed-point unit.
// Tracks LAT pipeline stages of {valid, rt}, interlocks RAW hazards, and holds the wb register under back-pressure.
module fx1_issue_ctrl #(
  parameter int LAT  = 2,
  parameter int OPW  = 11,
  parameter int TAGW = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iss_valid,
  output logic            iss_ready,
  input  logic [0:OPW-1]  iss_op,
  input  logic [0:TAGW-1] iss_ra,
  input  logic [0:TAGW-1] iss_rb,
  input  logic            iss_rb_used,
  input  logic [0:TAGW-1] iss_rt,
  input  logic            flush,
  output logic            dp_ld,
  output logic [0:OPW-1]  dp_op,
  output logic            dp_adv,
  input  logic [0:127]    dp_result,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [0:TAGW-1] wb_rt,
  output logic [0:127]    wb_data,
  output logic [2:0]      inflight
);

  logic [1:LAT]    st_v;
  logic [0:TAGW-1] st_rt [1:LAT];
  logic            stall;
  logic            adv;
  logic            hazard;
  logic            accept;
  logic [2:0]      cnt;

  assign stall  = st_v[LAT] & ~wb_ready;
  assign adv    = ~stall;
  assign dp_adv = rst_n & adv;

  // Every valid stage, including the wb register, still owes a write to its rt.
  always_comb begin
    hazard = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      if (st_v[k] && ((st_rt[k] == iss_ra) || (iss_rb_used && (st_rt[k] == iss_rb))))
        hazard = 1'b1;
    end
  end

  assign iss_ready = rst_n & adv & ~hazard & ~flush;
  assign accept    = iss_valid & iss_ready;
  assign dp_ld     = accept;
  assign dp_op     = iss_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_v <= '0;
      for (int k = 1; k <= LAT; k++) st_rt[k] <= '0;
    end else if (flush) begin
      st_v <= '0;
    end else if (adv) begin
      st_v[1] <= accept;
      if (accept) st_rt[1] <= iss_rt;
      for (int k = 2; k <= LAT; k++) begin
        st_v[k]  <= st_v[k-1];
        st_rt[k] <= st_rt[k-1];
      end
    end
  end

  generate
    if (LAT >= 2) begin : g_multi
      logic [0:127] wb_data_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          wb_data_q <= '0;
        else if (!flush && adv && st_v[LAT-1])
          wb_data_q <= dp_result;
      end
      assign wb_data = wb_data_q;
    end else begin : g_single
      // FX1 result only exists the cycle after dp_ld: pass it through while fresh, then hold it.
      logic         fresh;
      logic [0:127] wb_data_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          fresh     <= 1'b0;
          wb_data_q <= '0;
        end else begin
          fresh <= accept & ~flush;
          if (fresh) wb_data_q <= dp_result;
        end
      end
      assign wb_data = fresh ? dp_result : wb_data_q;
    end
  endgenerate

  assign wb_valid = st_v[LAT];
  assign wb_rt    = st_rt[LAT];

  always_comb begin
    cnt = '0;
    for (int k = 1; k <= LAT; k++) cnt = cnt + 3'(st_v[k]);
  end
  assign inflight = cnt;

endmodule

// File: tb/tb_fx1_issue_ctrl.sv
// Directed bench for fx1_issue_ctrl: a LAT=2 instance for most scenarios and a LAT=1 instance
// sharing the same inputs for the single-stage build.
module tb_fx1_issue_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         iss_valid;
  logic [0:10]  iss_op;
  logic [0:6]   iss_ra, iss_rb, iss_rt;
  logic         iss_rb_used;
  logic         flush;
  logic         wb_ready;
  logic [0:127] dp_result;

  logic         iss_ready2, dp_ld2, dp_adv2, wb_valid2;
  logic [0:10]  dp_op2;
  logic [0:6]   wb_rt2;
  logic [0:127] wb_data2;
  logic [2:0]   inflight2;

  logic         iss_ready1, dp_ld1, dp_adv1, wb_valid1;
  logic [0:10]  dp_op1;
  logic [0:6]   wb_rt1;
  logic [0:127] wb_data1;
  logic [2:0]   inflight1;

  int checks = 0;
  int failures = 0;

  localparam logic [0:10] OP_AHI = 11'h01d;
  localparam logic [0:127] D_A = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [0:127] D_B = 128'h9999_aaaa_bbbb_cccc_dddd_eeee_ffff_0001;
  localparam logic [0:127] D_G = 128'hdead_beef_dead_beef_dead_beef_dead_beef;

  always #5 clk = ~clk;

  fx1_issue_ctrl #(.LAT(2), .OPW(11), .TAGW(7)) dut2 (
    .clk(clk), .rst_n(rst_n), .iss_valid(iss_valid), .iss_ready(iss_ready2), .iss_op(iss_op),
    .iss_ra(iss_ra), .iss_rb(iss_rb), .iss_rb_used(iss_rb_used), .iss_rt(iss_rt), .flush(flush),
    .dp_ld(dp_ld2), .dp_op(dp_op2), .dp_adv(dp_adv2), .dp_result(dp_result), .wb_valid(wb_valid2),
    .wb_ready(wb_ready), .wb_rt(wb_rt2), .wb_data(wb_data2), .inflight(inflight2));

  fx1_issue_ctrl #(.LAT(1), .OPW(11), .TAGW(7)) dut1 (
    .clk(clk), .rst_n(rst_n), .iss_valid(iss_valid), .iss_ready(iss_ready1), .iss_op(iss_op),
    .iss_ra(iss_ra), .iss_rb(iss_rb), .iss_rb_used(iss_rb_used), .iss_rt(iss_rt), .flush(flush),
    .dp_ld(dp_ld1), .dp_op(dp_op1), .dp_adv(dp_adv1), .dp_result(dp_result), .wb_valid(wb_valid1),
    .wb_ready(wb_ready), .wb_rt(wb_rt1), .wb_data(wb_data1), .inflight(inflight1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [0:6] ra, input logic [0:6] rb, input logic rbu, input logic [0:6] rt);
    iss_valid = 1'b1; iss_op = OP_AHI; iss_ra = ra; iss_rb = rb; iss_rb_used = rbu; iss_rt = rt;
  endtask

  task automatic idle();
    iss_valid = 1'b0; iss_ra = 7'd0; iss_rb = 7'd0; iss_rb_used = 1'b0; iss_rt = 7'd0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; wb_ready = 1'b1; dp_result = '0; iss_op = '0;
    issue(7'd1, 7'd0, 1'b0, 7'd2);
    @(negedge clk);
    checks++; if (iss_ready2 !== 1'b0) begin failures++; $display("FAIL rst_iss_ready got=%b exp=0", iss_ready2); end
    checks++; if (dp_adv2 !== 1'b0) begin failures++; $display("FAIL rst_dp_adv got=%b exp=0", dp_adv2); end
    checks++; if (dp_ld2 !== 1'b0) begin failures++; $display("FAIL rst_dp_ld got=%b exp=0", dp_ld2); end
    idle();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (wb_valid2 !== 1'b0) begin failures++; $display("FAIL reset_wb_valid got=%b exp=0", wb_valid2); end
    checks++; if (inflight2 !== 3'd0) begin failures++; $display("FAIL reset_inflight got=%0d exp=0", inflight2); end
    checks++; if (wb_data2 !== '0) begin failures++; $display("FAIL reset_wb_data got=%h exp=0", wb_data2); end
    checks++; if (iss_ready2 !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%b exp=1", iss_ready2); end
    tick();
    issue(7'd1, 7'd0, 1'b0, 7'd3); tick();
    issue(7'd2, 7'd0, 1'b0, 7'd4); dp_result = D_A; tick();
    idle(); wb_ready = 1'b0;
    @(negedge clk);
    checks++; if (inflight2 !== 3'd2) begin failures++; $display("FAIL midrst_pre_inflight got=%0d exp=2", inflight2); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (wb_valid2 !== 1'b0) begin failures++; $display("FAIL midrst_wb_valid got=%b exp=0", wb_valid2); end
    checks++; if (inflight2 !== 3'd0) begin failures++; $display("FAIL midrst_inflight got=%0d exp=0", inflight2); end
    checks++; if (wb_rt2 !== 7'd0) begin failures++; $display("FAIL midrst_wb_rt got=%0d exp=0", wb_rt2); end
    tick();
    rst_n = 1'b1; wb_ready = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    wb_ready = 1'b1;
    issue(7'd1, 7'd0, 1'b0, 7'd3);
    @(negedge clk);
    checks++; if (dp_ld2 !== 1'b1) begin failures++; $display("FAIL b2b_dp_ld0 got=%b exp=1", dp_ld2); end
    checks++; if (dp_op2 !== OP_AHI) begin failures++; $display("FAIL b2b_dp_op got=%h exp=%h", dp_op2, OP_AHI); end
    tick();
    issue(7'd2, 7'd0, 1'b0, 7'd4); dp_result = D_A;
    @(negedge clk);
    checks++; if (dp_ld2 !== 1'b1) begin failures++; $display("FAIL b2b_dp_ld1 got=%b exp=1", dp_ld2); end
    checks++; if (inflight2 !== 3'd1) begin failures++; $display("FAIL b2b_inflight1 got=%0d exp=1", inflight2); end
    checks++; if (wb_valid2 !== 1'b0) begin failures++; $display("FAIL b2b_wb_valid1 got=%b exp=0", wb_valid2); end
    tick();
    idle(); dp_result = D_B;
    @(negedge clk);
    checks++; if (wb_valid2 !== 1'b1 || wb_rt2 !== 7'd3) begin failures++; $display("FAIL b2b_wb_c2 got=%b/%0d exp=1/3", wb_valid2, wb_rt2); end
    checks++; if (wb_data2 !== D_A) begin failures++; $display("FAIL b2b_data_c2 got=%h exp=%h", wb_data2, D_A); end
    checks++; if (inflight2 !== 3'd2) begin failures++; $display("FAIL b2b_inflight2 got=%0d exp=2", inflight2); end
    tick();
    @(negedge clk);
    checks++; if (wb_valid2 !== 1'b1 || wb_rt2 !== 7'd4) begin failures++; $display("FAIL b2b_wb_c3 got=%b/%0d exp=1/4", wb_valid2, wb_rt2); end
    checks++; if (wb_data2 !== D_B) begin failures++; $display("FAIL b2b_data_c3 got=%h exp=%h", wb_data2, D_B); end
    checks++; if (inflight2 !== 3'd1) begin failures++; $display("FAIL b2b_inflight3 got=%0d exp=1", inflight2); end
    tick();
    @(negedge clk);
    checks++; if (wb_valid2 !== 1'b0 || inflight2 !== 3'd0) begin failures++; $display("FAIL b2b_drained got=%b/%0d exp=0/0", wb_valid2, inflight2); end
    tick();
  endtask

  task automatic test_raw();
    wb_ready = 1'b1;
    issue(7'd10, 7'd0, 1'b0, 7'd5); tick();
    issue(7'd5, 7'd0, 1'b0, 7'd6);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      checks++; if (iss_ready2 !== 1'b0) begin failures++; $display("FAIL raw_blocked_c%0d got=%b exp=0", c, iss_ready2); end
      tick();
    end
    @(negedge clk);
    checks++; if (iss_ready2 !== 1'b1 || dp_ld2 !== 1'b1) begin failures++; $display("FAIL raw_accept_c3 got=%b/%b exp=1/1", iss_ready2, dp_ld2); end
    tick();
    idle(); tick(); tick(); tick();
    issue(7'd10, 7'd0, 1'b0, 7'd5); tick();
    issue(7'd9, 7'd5, 1'b0, 7'd7);
    @(negedge clk);
    checks++; if (iss_ready2 !== 1'b1) begin failures++; $display("FAIL raw_rb_unused got=%b exp=1", iss_ready2); end
    tick();
    issue(7'd9, 7'd5, 1'b1, 7'd8);
    @(negedge clk);
    checks++; if (iss_ready2 !== 1'b0) begin failures++; $display("FAIL raw_rb_used got=%b exp=0", iss_ready2); end
    tick();
    idle(); tick(); tick(); tick();
  endtask

  task automatic test_backpressure();
    wb_ready = 1'b1;
    issue(7'd20, 7'd0, 1'b0, 7'd11); tick();
    issue(7'd21, 7'd0, 1'b0, 7'd12); dp_result = D_A; tick();
    issue(7'd22, 7'd0, 1'b0, 7'd13); wb_ready = 1'b0; dp_result = D_G;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (wb_valid2 !== 1'b1 || wb_rt2 !== 7'd11) begin failures++; $display("FAIL bp_hold_rt_c%0d got=%b/%0d exp=1/11", c, wb_valid2, wb_rt2); end
      checks++; if (wb_data2 !== D_A) begin failures++; $display("FAIL bp_hold_data_c%0d got=%h exp=%h", c, wb_data2, D_A); end
      checks++; if (iss_ready2 !== 1'b0 || dp_adv2 !== 1'b0) begin failures++; $display("FAIL bp_ready_adv_c%0d got=%b/%b exp=0/0", c, iss_ready2, dp_adv2); end
      checks++; if (inflight2 !== 3'd2) begin failures++; $display("FAIL bp_inflight_c%0d got=%0d exp=2", c, inflight2); end
      tick();
    end
    wb_ready = 1'b1; dp_result = D_B;
    @(negedge clk);
    checks++; if (iss_ready2 !== 1'b1 || wb_rt2 !== 7'd11) begin failures++; $display("FAIL bp_release got=%b/%0d exp=1/11", iss_ready2, wb_rt2); end
    checks++; if (inflight2 !== 3'd2) begin failures++; $display("FAIL bp_acc_and_hs got=%0d exp=2", inflight2); end
    tick();
    idle(); dp_result = D_A;
    @(negedge clk);
    checks++; if (wb_rt2 !== 7'd12 || wb_data2 !== D_B) begin failures++; $display("FAIL bp_drain12 got=%0d/%h exp=12/%h", wb_rt2, wb_data2, D_B); end
    checks++; if (inflight2 !== 3'd2) begin failures++; $display("FAIL bp_drain_inflight got=%0d exp=2", inflight2); end
    tick();
    @(negedge clk);
    checks++; if (wb_rt2 !== 7'd13 || wb_data2 !== D_A) begin failures++; $display("FAIL bp_drain13 got=%0d/%h exp=13/%h", wb_rt2, wb_data2, D_A); end
    tick();
    @(negedge clk);
    checks++; if (wb_valid2 !== 1'b0 || inflight2 !== 3'd0) begin failures++; $display("FAIL bp_empty got=%b/%0d exp=0/0", wb_valid2, inflight2); end
    tick();
  endtask

  task automatic test_flush();
    wb_ready = 1'b1;
    issue(7'd1, 7'd0, 1'b0, 7'd30); tick();
    issue(7'd2, 7'd0, 1'b0, 7'd31); tick();
    issue(7'd3, 7'd0, 1'b0, 7'd32); flush = 1'b1; wb_ready = 1'b0;
    @(negedge clk);
    checks++; if (iss_ready2 !== 1'b0 || dp_ld2 !== 1'b0) begin failures++; $display("FAIL flush_no_accept got=%b/%b exp=0/0", iss_ready2, dp_ld2); end
    checks++; if (inflight2 !== 3'd2) begin failures++; $display("FAIL flush_pre_inflight got=%0d exp=2", inflight2); end
    tick();
    flush = 1'b0; idle(); wb_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (wb_valid2 !== 1'b0 || inflight2 !== 3'd0) begin failures++; $display("FAIL flush_empty_c%0d got=%b/%0d exp=0/0", c, wb_valid2, inflight2); end
      tick();
    end
  endtask

  task automatic test_lat1();
    do_reset();
    wb_ready = 1'b1;
    issue(7'd1, 7'd0, 1'b0, 7'd40);
    @(negedge clk);
    checks++; if (iss_ready1 !== 1'b1 || wb_valid1 !== 1'b0) begin failures++; $display("FAIL lat1_c0 got=%b/%b exp=1/0", iss_ready1, wb_valid1); end
    tick();
    issue(7'd40, 7'd0, 1'b0, 7'd41); dp_result = D_A;
    @(negedge clk);
    checks++; if (wb_valid1 !== 1'b1 || wb_rt1 !== 7'd40) begin failures++; $display("FAIL lat1_wb_c1 got=%b/%0d exp=1/40", wb_valid1, wb_rt1); end
    checks++; if (wb_data1 !== D_A) begin failures++; $display("FAIL lat1_data_c1 got=%h exp=%h", wb_data1, D_A); end
    checks++; if (iss_ready1 !== 1'b0) begin failures++; $display("FAIL lat1_wb_hazard got=%b exp=0", iss_ready1); end
    tick();
    @(negedge clk);
    checks++; if (wb_valid1 !== 1'b0 || iss_ready1 !== 1'b1) begin failures++; $display("FAIL lat1_c2 got=%b/%b exp=0/1", wb_valid1, iss_ready1); end
    tick();
    idle(); dp_result = D_B; wb_ready = 1'b0;
    @(negedge clk);
    checks++; if (wb_valid1 !== 1'b1 || wb_rt1 !== 7'd41 || wb_data1 !== D_B) begin failures++; $display("FAIL lat1_c3 got=%b/%0d/%h exp=1/41/%h", wb_valid1, wb_rt1, wb_data1, D_B); end
    tick();
    @(negedge clk);
    checks++; if (wb_valid1 !== 1'b1 || wb_data1 !== D_B) begin failures++; $display("FAIL lat1_stall_hold got=%b/%h exp=1/%h", wb_valid1, wb_data1, D_B); end
    wb_ready = 1'b1;
    tick();
    @(negedge clk);
    checks++; if (wb_valid1 !== 1'b0 || inflight1 !== 3'd0) begin failures++; $display("FAIL lat1_empty got=%b/%0d exp=0/0", wb_valid1, inflight1); end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_raw();
    test_backpressure();
    test_flush();
    test_lat1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
